// File: rtl/md_ctrl.sv
// HI/LO controller: dispatches multiply/divide to external units, tracks completion with a watchdog.
// Optional MD_CTRL_BYPASS_EN: forwards a completing result straight to MFHI/MFLO.
module md_ctrl #(
   parameter int unsigned MAX_WAIT = 40
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_src1,
   input  logic [31:0] req_src2,
   output logic        req_ready,
   input  logic        flush,
   output logic        mul_en,
   output logic        div_en,
   output logic        md_signed,
   output logic [31:0] md_src1,
   output logic [31:0] md_src2,
   input  logic        mul_complete,
   input  logic        div_complete,
   input  logic [63:0] md_result,
   output logic        rd_valid,
   output logic [31:0] rd_data,
   output logic        md_busy,
   output logic        md_timeout
);
   localparam int unsigned CW = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, ABORT} state_t;

   state_t        r_state;
   logic [31:0]   r_hi;
   logic [31:0]   r_lo;
   logic [CW-1:0] r_cnt;
   logic          r_timeout;

   logic w_is_mul, w_is_div, w_is_mf, w_is_mt;
   logic w_done, w_fwd, w_accept, w_limit;

   assign w_is_mul = (req_op[2:1] == 2'b00);
   assign w_is_div = (req_op[2:1] == 2'b01);
   assign w_is_mf  = (req_op[2:1] == 2'b10);
   assign w_is_mt  = (req_op[2:1] == 2'b11);

   assign w_done  = ((r_state == MUL_WAIT) && mul_complete) ||
                    ((r_state == DIV_WAIT) && div_complete);
   assign w_limit = (r_cnt == CW'(MAX_WAIT - 1));

`ifdef MD_CTRL_BYPASS_EN
   assign w_fwd = w_done & ~flush;
`else
   assign w_fwd = 1'b0;
`endif

   assign req_ready = (r_state == IDLE) || (w_fwd && w_is_mf);
   assign w_accept  = req_valid & req_ready & ~flush & ~reset;

   assign mul_en    = w_accept & w_is_mul & (r_state == IDLE);
   assign div_en    = w_accept & w_is_div & (r_state == IDLE);
   assign md_signed = ~reset & ~req_op[2] & ~req_op[0];
   assign md_src1   = reset ? '0 : req_src1;
   assign md_src2   = reset ? '0 : req_src2;

   assign rd_valid  = w_accept & w_is_mf;
   always_comb begin
      rd_data = '0;
      if (rd_valid) begin
         if (w_fwd) rd_data = req_op[0] ? md_result[31:0] : md_result[63:32];
         else       rd_data = req_op[0] ? r_lo : r_hi;
      end
   end

   assign md_busy    = (r_state != IDLE);
   assign md_timeout = r_timeout;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_hi      <= '0;
         r_lo      <= '0;
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (w_is_mul) begin
                     r_state <= MUL_WAIT;
                     r_cnt   <= '0;
                  end else if (w_is_div) begin
                     r_state <= DIV_WAIT;
                     r_cnt   <= '0;
                  end else if (w_is_mt) begin
                     if (req_op[0]) r_lo <= req_src1;
                     else           r_hi <= req_src1;
                  end
               end
            end
            MUL_WAIT, DIV_WAIT: begin
               // A completion coinciding with flush consumes the unit's result, so there is nothing left to abort.
               if (w_done) begin
                  if (!flush) begin
                     r_hi <= md_result[63:32];
                     r_lo <= md_result[31:0];
                  end
                  r_state <= IDLE;
               end else if (w_limit) begin
                  r_state   <= IDLE;
                  r_timeout <= 1'b1;
                  r_cnt     <= r_cnt + CW'(1);
               end else begin
                  r_cnt <= r_cnt + CW'(1);
                  if (flush) r_state <= ABORT;
               end
            end
            ABORT: begin
               if (mul_complete || div_complete) begin
                  r_state <= IDLE;
               end else if (w_limit) begin
                  r_state   <= IDLE;
                  r_timeout <= 1'b1;
                  r_cnt     <= r_cnt + CW'(1);
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: an operation-level model checked every cycle, plus literal spot checks.
module tb_md_ctrl;
   localparam int MAXW = 40;
`ifdef MD_CTRL_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic [2:0]  req_op = 3'd0;
   logic [31:0] req_src1 = '0, req_src2 = '0;
   logic        req_ready, flush = 1'b0;
   logic        mul_en, div_en, md_signed;
   logic [31:0] md_src1, md_src2;
   logic        mul_complete = 1'b0, div_complete = 1'b0;
   logic [63:0] md_result = '0;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        md_busy, md_timeout;

   int checks = 0;
   int failures = 0;

   md_ctrl #(.MAX_WAIT(MAXW)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
      .req_src1(req_src1), .req_src2(req_src2), .req_ready(req_ready), .flush(flush),
      .mul_en(mul_en), .div_en(div_en), .md_signed(md_signed),
      .md_src1(md_src1), .md_src2(md_src2), .mul_complete(mul_complete),
      .div_complete(div_complete), .md_result(md_result), .rd_valid(rd_valid),
      .rd_data(rd_data), .md_busy(md_busy), .md_timeout(md_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: which operation is outstanding (0 none, 1 mul, 2 div, 3 flushed),
   // the cycle it was issued, the architectural HI/LO and a pending timeout flag.
   int          pend = 0;
   int          issued = 0;
   int          ncyc = 0;
   logic [31:0] mhi = '0, mlo = '0;
   bit          mto = 1'b0;

   always @(negedge clk) begin
      bit ex_rdy, acc, fwd, mf, is_mul, is_div;
      logic [31:0] ex_rd;
      ncyc++;
      mf     = (req_op == 3'd4) || (req_op == 3'd5);
      is_mul = (req_op == 3'd0) || (req_op == 3'd1);
      is_div = (req_op == 3'd2) || (req_op == 3'd3);
      fwd    = BYP && !flush && ((pend == 1 && mul_complete) || (pend == 2 && div_complete));
      ex_rdy = reset || (pend == 0) || (fwd && mf);
      acc    = req_valid && ex_rdy && !flush && !reset;
      ex_rd  = '0;
      if (acc && mf) begin
         if (fwd) ex_rd = (req_op == 3'd4) ? md_result[63:32] : md_result[31:0];
         else     ex_rd = (req_op == 3'd4) ? mhi : mlo;
      end
      chk("req_ready", 64'(req_ready), 64'(ex_rdy));
      chk("mul_en", 64'(mul_en), 64'(acc && pend == 0 && is_mul));
      chk("div_en", 64'(div_en), 64'(acc && pend == 0 && is_div));
      chk("md_signed", 64'(md_signed), 64'(!reset && (req_op == 3'd0 || req_op == 3'd2)));
      chk("md_src1", 64'(md_src1), reset ? 64'd0 : 64'(req_src1));
      chk("md_src2", 64'(md_src2), reset ? 64'd0 : 64'(req_src2));
      chk("rd_valid", 64'(rd_valid), 64'(acc && mf));
      chk("rd_data", 64'(rd_data), 64'(ex_rd));
      chk("md_busy", 64'(md_busy), 64'(!reset && pend != 0));
      chk("md_timeout", 64'(md_timeout), 64'(!reset && mto));
      if (reset) begin
         pend = 0; mhi = '0; mlo = '0; mto = 1'b0;
      end else begin
         mto = 1'b0;
         if (pend == 0) begin
            if (acc && is_mul) begin pend = 1; issued = ncyc; end
            else if (acc && is_div) begin pend = 2; issued = ncyc; end
            else if (acc && req_op == 3'd6) mhi = req_src1;
            else if (acc && req_op == 3'd7) mlo = req_src1;
         end else if ((pend == 1 && mul_complete) || (pend == 2 && div_complete)) begin
            if (!flush) begin mhi = md_result[63:32]; mlo = md_result[31:0]; end
            pend = 0;
         end else if (pend == 3 && (mul_complete || div_complete)) begin
            pend = 0;
         end else if (ncyc - issued == MAXW) begin
            pend = 0; mto = 1'b1;
         end else if (flush) begin
            pend = 3;
         end
      end
   end

   task automatic apply(input logic v, input logic [2:0] op, input logic [31:0] s1,
                        input logic [31:0] s2, input logic fl, input logic mc,
                        input logic dc, input logic [63:0] res, input logic rst);
      @(posedge clk); #1;
      reset = rst; req_valid = v; req_op = op; req_src1 = s1; req_src2 = s2;
      flush = fl; mul_complete = mc; div_complete = dc; md_result = res;
      @(negedge clk);
   endtask

   task automatic idle();
      apply(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic req(input logic [2:0] op, input logic [31:0] s1, input logic [31:0] s2);
      apply(1'b1, op, s1, s2, 1'b0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   initial begin
      int n;
      // Reset with a MULT request presented: nothing may start.
      apply(1'b1, 3'd0, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0, 1'b0, '0, 1'b1);
      chk("lit_reset_ready", 64'(req_ready), 64'd1);
      chk("lit_reset_mul_en", 64'(mul_en), 64'd0);
      apply(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
      idle();

      // Signed multiply, completion three cycles after acceptance.
      req(3'd0, 32'hFFFF_FFFE, 32'd3);
      chk("lit_mult_en", 64'(mul_en), 64'd1);
      chk("lit_mult_signed", 64'(md_signed), 64'd1);
      idle(); idle();
      apply(1'b0, 3'd0, '0, '0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
      req(3'd5, '0, '0);
      chk("lit_mflo_mult", 64'(rd_data), 64'hFFFF_FFFA);
      req(3'd4, '0, '0);
      chk("lit_mfhi_mult", 64'(rd_data), 64'hFFFF_FFFF);

      // MTHI then MFHI.
      req(3'd6, 32'h1234_5678, '0);
      req(3'd4, '0, '0);
      chk("lit_mthi_mfhi", 64'(rd_data), 64'h1234_5678);
      chk("lit_mthi_nostart", 64'({mul_en, div_en}), 64'd0);
      req(3'd7, 32'hA5A5_0001, '0);

      // Unsigned divide 17/5 with an MFLO held while waiting.
      req(3'd3, 32'd17, 32'd5);
      chk("lit_divu_en", 64'(div_en), 64'd1);
      chk("lit_divu_unsigned", 64'(md_signed), 64'd0);
      req(3'd5, '0, '0);
      chk("lit_mflo_stall", 64'(req_ready), 64'd0);
      req(3'd5, '0, '0);
      apply(1'b1, 3'd5, '0, '0, 1'b0, 1'b0, 1'b1, {32'd2, 32'd3}, 1'b0);
      req(3'd5, '0, '0);
      chk("lit_mflo_div", 64'(rd_data), 64'd3);
      req(3'd4, '0, '0);
      chk("lit_mfhi_div", 64'(rd_data), 64'd2);

      // MULT, flush in cycle 2, complete in cycle 4: HI/LO untouched.
      req(3'd1, 32'd7, 32'd9);
      apply(1'b0, 3'd0, '0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      idle();
      chk("lit_abort_busy", 64'(md_busy), 64'd1);
      apply(1'b0, 3'd0, '0, '0, 1'b0, 1'b1, 1'b0, 64'h1111_1111_2222_2222, 1'b0);
      idle();
      chk("lit_abort_idle", 64'(md_busy), 64'd0);
      req(3'd4, '0, '0);
      chk("lit_abort_hi", 64'(rd_data), 64'd2);

      // Flush together with completion discards the result; flush blocks MTLO in IDLE.
      req(3'd2, 32'hFFFF_FFF0, 32'd4);
      apply(1'b0, 3'd0, '0, '0, 1'b1, 1'b0, 1'b1, 64'h9999_9999_8888_8888, 1'b0);
      apply(1'b1, 3'd7, 32'h5555_5555, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      req(3'd5, '0, '0);
      chk("lit_discard_lo", 64'(rd_data), 64'd3);

      // Bypass path (or its stall when disabled) on MFHI coincident with mul_complete.
      req(3'd0, 32'd2, 32'd3);
      idle();
      apply(1'b1, 3'd4, '0, '0, 1'b0, 1'b1, 1'b0, 64'h0000_00AB_0000_00CD, 1'b0);
      if (BYP) chk("lit_bypass_hi", 64'(rd_data), 64'hAB);
      else     chk("lit_bypass_stall", 64'(req_ready), 64'd0);
      req(3'd4, '0, '0);

      // Divider never completes: watchdog.
      req(3'd2, 32'd1, 32'd0);
      n = 1;
      while (n <= 50) begin
         idle();
         if (md_timeout) break;
         n++;
      end
      chk("lit_timeout_cycle", 64'(n), 64'd41);
      chk("lit_timeout_ready", 64'(req_ready), 64'd1);
      apply(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b1, 64'h7777_7777_6666_6666, 1'b0);
      req(3'd4, '0, '0);

      // Reset mid-operation; a late complete is ignored.
      req(3'd0, 32'd5, 32'd5);
      idle();
      apply(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
      idle();
      apply(1'b0, 3'd0, '0, '0, 1'b0, 1'b1, 1'b0, 64'h4444_4444_3333_3333, 1'b0);
      req(3'd4, '0, '0);
      chk("lit_reset_hi", 64'(rd_data), 64'd0);
      chk("lit_reset_busy", 64'(md_busy), 64'd0);
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
